// File: rtl/ball_pkg.sv
// Shared widths, shape encoding and the per-axis bounce rule for the ball sprite engine.
package ball_pkg;
  localparam int COORD_W = 11;
  localparam int SQ_W    = 23;

  typedef enum logic [1:0] {
    SHAPE_CIRCLE  = 2'd0,
    SHAPE_SQUARE  = 2'd1,
    SHAPE_DIAMOND = 2'd2
  } shape_e;

  typedef struct packed {
    logic [COORD_W-1:0] p;
    logic [COORD_W-1:0] v;
  } axis_t;

  // Advance one axis, clamping to [r, res-1-r] and reflecting the velocity on contact.
  function automatic axis_t bounce(input logic [COORD_W-1:0] p, input logic [COORD_W-1:0] v,
                                   input logic [COORD_W-1:0] r, input int res);
    axis_t o;
    int    n, lo, hi, sv;
    sv  = int'($signed(v));
    n   = int'(p) + sv;
    lo  = int'(r);
    hi  = res - 1 - lo;
    o.p = COORD_W'(n);
    o.v = v;
    if (hi < lo) begin
      o.p = COORD_W'(lo);
    end else if (n >= hi && sv > 0) begin
      o.p = COORD_W'(hi);
      o.v = -v;
    end else if (n <= lo && sv < 0) begin
      o.p = COORD_W'(lo);
      o.v = -v;
    end
    return o;
  endfunction
endpackage

// File: rtl/ball_motion.sv
// One ball: position/velocity registers, sticky reversal request and per-frame bounce update.
module ball_motion
  import ball_pkg::*;
#(
  parameter int                 X_RES   = 640,
  parameter int                 Y_RES   = 480,
  parameter logic [COORD_W-1:0] INIT_X  = 11'd64,
  parameter logic [COORD_W-1:0] INIT_Y  = 11'd48,
  parameter logic [COORD_W-1:0] INIT_VX = 11'd2,
  parameter logic [COORD_W-1:0] INIT_VY = 11'd1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_tick,
  input  logic               i_freeze,
  input  logic               i_opposite,
  input  logic               i_bump,
  input  logic [COORD_W-1:0] i_radius,
  output logic [COORD_W-1:0] o_px,
  output logic [COORD_W-1:0] o_py
);
  logic [COORD_W-1:0] r_px, r_py, r_vx, r_vy;
  logic               r_req;
  logic               w_upd, w_rev;
  logic [COORD_W-1:0] w_vx, w_vy;
  axis_t              w_ax, w_ay;

  assign w_upd = i_tick & ~i_freeze;
  // Reversal is applied before the bounce so an edge hit reflects the already-negated velocity.
  assign w_rev = r_req | i_opposite | i_bump;
  assign w_vx  = w_rev ? -r_vx : r_vx;
  assign w_vy  = w_rev ? -r_vy : r_vy;
  assign w_ax  = bounce(r_px, w_vx, i_radius, X_RES);
  assign w_ay  = bounce(r_py, w_vy, i_radius, Y_RES);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_px  <= INIT_X;
      r_py  <= INIT_Y;
      r_vx  <= INIT_VX;
      r_vy  <= INIT_VY;
      r_req <= 1'b0;
    end else if (w_upd) begin
      r_px  <= w_ax.p;
      r_py  <= w_ay.p;
      r_vx  <= w_ax.v;
      r_vy  <= w_ay.v;
      r_req <= 1'b0;
    end else begin
      r_req <= r_req | i_opposite;
    end
  end

  // The renderer sees the freshly updated position on the tick cycle itself.
  assign o_px = w_upd ? w_ax.p : r_px;
  assign o_py = w_upd ? w_ay.p : r_py;
endmodule

// File: rtl/ball_array.sv
// N-ball sprite engine: per-ball motion plus a fixed 3-stage per-pixel render pipeline.
// Optional BALL_ARRAY_COLLIDE_EN: balls seen overlapping during a frame reverse at the next tick.
module ball_array
  import ball_pkg::*;
#(
  parameter int  N_BALLS = 4,
  parameter int  X_RES   = 640,
  parameter int  Y_RES   = 480,
  parameter int  START_X = 64,
  parameter int  START_Y = 48,
  parameter int  STEP_X  = 96,
  parameter int  STEP_Y  = 64,
  parameter int  DELTA_X = 2,
  parameter int  DELTA_Y = 1,
  localparam int ID_W    = (N_BALLS > 1) ? $clog2(N_BALLS) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [COORD_W-1:0] i_hcnt,
  input  logic [COORD_W-1:0] i_vcnt,
  input  logic [COORD_W-1:0] i_radius,
  input  logic [1:0]         i_mode,
  input  logic [N_BALLS-1:0] i_opposite,
  input  logic               i_freeze,
  output logic               o_draw,
  output logic [ID_W-1:0]    o_ball_id,
  output logic               o_overlap,
  output logic               o_tick
);
  logic r_zero_d, r_tick, w_zero, w_tick;

  // A frame starts on the first cycle at (0,0); holding there does not retrigger.
  assign w_zero = (i_hcnt == '0) && (i_vcnt == '0);
  assign w_tick = w_zero & ~r_zero_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_zero_d <= 1'b0;
      r_tick   <= 1'b0;
    end else begin
      r_zero_d <= w_zero;
      r_tick   <= w_tick;
    end
  end
  assign o_tick = r_tick;

  logic [N_BALLS-1:0][COORD_W-1:0] w_px, w_py, w_dx, w_dy;
  logic [N_BALLS-1:0]              w_bump, w_hit;
  logic                            w_ovl;

  for (genvar k = 0; k < N_BALLS; k++) begin : g_ball
    localparam int VX0 = (k % 2 == 1) ? -DELTA_X : DELTA_X;
    localparam int VY0 = (k % 2 == 1) ? -DELTA_Y : DELTA_Y;
    ball_motion #(
      .X_RES  (X_RES),
      .Y_RES  (Y_RES),
      .INIT_X (COORD_W'(START_X + k * STEP_X)),
      .INIT_Y (COORD_W'(START_Y + k * STEP_Y)),
      .INIT_VX(COORD_W'(VX0)),
      .INIT_VY(COORD_W'(VY0))
    ) u_mot (
      .clk       (clk),
      .rst       (rst),
      .i_tick    (w_tick),
      .i_freeze  (i_freeze),
      .i_opposite(i_opposite[k]),
      .i_bump    (w_bump[k]),
      .i_radius  (i_radius),
      .o_px      (w_px[k]),
      .o_py      (w_py[k])
    );
    assign w_dx[k] = (i_hcnt >= w_px[k]) ? i_hcnt - w_px[k] : w_px[k] - i_hcnt;
    assign w_dy[k] = (i_vcnt >= w_py[k]) ? i_vcnt - w_py[k] : w_py[k] - i_vcnt;
  end

  logic [N_BALLS-1:0][COORD_W-1:0]   r_dx1, r_dy1, r_dx2, r_dy2;
  logic [N_BALLS-1:0][2*COORD_W-1:0] r_dxsq, r_dysq;
  logic [N_BALLS-1:0][COORD_W:0]     r_sum;
  logic [COORD_W-1:0]                r_rad1, r_rad2;
  logic [1:0]                        r_mode1, r_mode2;

  // Radius and mode travel with the pixel so a mid-line change stays aligned.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dx1   <= '0;
      r_dy1   <= '0;
      r_dx2   <= '0;
      r_dy2   <= '0;
      r_dxsq  <= '0;
      r_dysq  <= '0;
      r_sum   <= '0;
      r_rad1  <= '0;
      r_rad2  <= '0;
      r_mode1 <= '0;
      r_mode2 <= '0;
    end else begin
      r_dx1   <= w_dx;
      r_dy1   <= w_dy;
      r_rad1  <= i_radius;
      r_mode1 <= i_mode;
      for (int k = 0; k < N_BALLS; k++) begin
        r_dxsq[k] <= (2*COORD_W)'(r_dx1[k]) * (2*COORD_W)'(r_dx1[k]);
        r_dysq[k] <= (2*COORD_W)'(r_dy1[k]) * (2*COORD_W)'(r_dy1[k]);
        r_sum[k]  <= {1'b0, r_dx1[k]} + {1'b0, r_dy1[k]};
      end
      r_dx2   <= r_dx1;
      r_dy2   <= r_dy1;
      r_rad2  <= r_rad1;
      r_mode2 <= r_mode1;
    end
  end

  logic [2*COORD_W-1:0] w_rsq;
  logic [ID_W-1:0]      w_id;
  assign w_rsq = (2*COORD_W)'(r_rad2) * (2*COORD_W)'(r_rad2);

  always_comb begin
    w_hit = '0;
    for (int k = 0; k < N_BALLS; k++) begin
      case (r_mode2)
        SHAPE_SQUARE:  w_hit[k] = (r_dx2[k] < r_rad2) && (r_dy2[k] < r_rad2);
        SHAPE_DIAMOND: w_hit[k] = r_sum[k] < {1'b0, r_rad2};
        default:       w_hit[k] = (SQ_W'(r_dxsq[k]) + SQ_W'(r_dysq[k])) < SQ_W'(w_rsq);
      endcase
    end
  end

  always_comb begin
    w_id = '0;
    for (int k = N_BALLS - 1; k >= 0; k--) begin
      if (w_hit[k]) w_id = ID_W'(k);
    end
  end
  // Clearing the lowest set bit leaves something only when two or more balls hit.
  assign w_ovl = (w_hit & (w_hit - N_BALLS'(1))) != '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      o_draw    <= 1'b0;
      o_ball_id <= '0;
      o_overlap <= 1'b0;
    end else begin
      o_draw    <= |w_hit;
      o_ball_id <= w_id;
      o_overlap <= w_ovl;
    end
  end

`ifdef BALL_ARRAY_COLLIDE_EN
  logic [N_BALLS-1:0] r_hit_seen;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hit_seen <= '0;
    end else if (w_tick && !i_freeze) begin
      r_hit_seen <= '0;
    end else if (w_ovl) begin
      r_hit_seen <= r_hit_seen | w_hit;
    end
  end
  assign w_bump = r_hit_seen;
`else
  assign w_bump = '0;
`endif
endmodule

// File: tb/tb_ball_array.sv
// Bench for ball_array: table-driven render vectors through a latency scoreboard, plus
// hand-written motion sequences (freeze, sticky reversal, held-zero tick, edge bounce, overlap).
module tb_ball_array;
  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] hcnt, vcnt, radius;
  logic [1:0]  mode;
  logic [3:0]  opp;
  logic        freeze;
  logic        draw, ovl, tick;
  logic [1:0]  id;

  ball_array dut (
    .clk(clk), .rst(rst), .i_hcnt(hcnt), .i_vcnt(vcnt), .i_radius(radius), .i_mode(mode),
    .i_opposite(opp), .i_freeze(freeze), .o_draw(draw), .o_ball_id(id), .o_overlap(ovl),
    .o_tick(tick)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  typedef struct {
    int         due;
    logic [3:0] exp;
    string      name;
  } sb_t;
  sb_t sb[$];

  typedef struct {
    logic [10:0] r;
    logic [1:0]  m;
    logic [10:0] h, v;
    logic        d;
    logic [1:0]  i;
    logic        o;
  } vec_t;
  vec_t vt[17];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      sb_t e;
      e = sb.pop_front();
      chk(e.name, {60'd0, draw, id, ovl}, {60'd0, e.exp});
    end
  endtask

  task automatic expect_px(input string name, input int lat, input logic d, input logic [1:0] i,
                           input logic o);
    sb_t e;
    e.due  = cyc + lat;
    e.exp  = {d, i, o};
    e.name = name;
    sb.push_back(e);
  endtask

  task automatic drive(input int h, input int v);
    hcnt = 11'(h);
    vcnt = 11'(v);
  endtask

  function automatic logic [43:0] st(input int k);
    case (k)
      0: return {dut.g_ball[0].u_mot.r_px, dut.g_ball[0].u_mot.r_py,
                 dut.g_ball[0].u_mot.r_vx, dut.g_ball[0].u_mot.r_vy};
      1: return {dut.g_ball[1].u_mot.r_px, dut.g_ball[1].u_mot.r_py,
                 dut.g_ball[1].u_mot.r_vx, dut.g_ball[1].u_mot.r_vy};
      2: return {dut.g_ball[2].u_mot.r_px, dut.g_ball[2].u_mot.r_py,
                 dut.g_ball[2].u_mot.r_vx, dut.g_ball[2].u_mot.r_vy};
      default: return {dut.g_ball[3].u_mot.r_px, dut.g_ball[3].u_mot.r_py,
                       dut.g_ball[3].u_mot.r_vx, dut.g_ball[3].u_mot.r_vy};
    endcase
  endfunction

  task automatic chk_ball(input string name, input int k, input int px, input int py,
                          input int vx, input int vy);
    chk(name, {20'd0, st(k)}, {20'd0, 11'(px), 11'(py), 11'(vx), 11'(vy)});
  endtask

  task automatic reset_dut();
    rst    = 1'b1;
    opp    = '0;
    freeze = 1'b0;
    radius = 11'd10;
    mode   = 2'd0;
    drive(2000, 2000);
    step();
    step();
    rst = 1'b0;
  endtask

  // One frame: leave (0,0), hit it for one cycle (the tick edge), then park off-screen.
  task automatic frame();
    drive(2000, 2000);
    step();
    drive(0, 0);
    step();
    drive(2000, 2000);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    int ntick;
    vt[0]  = '{11'd10, 2'd0, 11'd64,   11'd48,   1'b1, 2'd0, 1'b0};
    vt[1]  = '{11'd10, 2'd0, 11'd70,   11'd55,   1'b1, 2'd0, 1'b0};
    vt[2]  = '{11'd10, 2'd0, 11'd70,   11'd56,   1'b0, 2'd0, 1'b0};
    vt[3]  = '{11'd10, 2'd0, 11'd72,   11'd56,   1'b0, 2'd0, 1'b0};
    vt[4]  = '{11'd10, 2'd3, 11'd71,   11'd55,   1'b1, 2'd0, 1'b0};
    vt[5]  = '{11'd10, 2'd1, 11'd73,   11'd57,   1'b1, 2'd0, 1'b0};
    vt[6]  = '{11'd10, 2'd1, 11'd74,   11'd48,   1'b0, 2'd0, 1'b0};
    vt[7]  = '{11'd10, 2'd2, 11'd68,   11'd53,   1'b1, 2'd0, 1'b0};
    vt[8]  = '{11'd10, 2'd2, 11'd69,   11'd53,   1'b0, 2'd0, 1'b0};
    vt[9]  = '{11'd10, 2'd2, 11'd71,   11'd55,   1'b0, 2'd0, 1'b0};
    vt[10] = '{11'd0,  2'd0, 11'd64,   11'd48,   1'b0, 2'd0, 1'b0};
    vt[11] = '{11'd49, 2'd1, 11'd112,  11'd80,   1'b1, 2'd0, 1'b1};
    vt[12] = '{11'd49, 2'd1, 11'd160,  11'd112,  1'b1, 2'd1, 1'b0};
    vt[13] = '{11'd49, 2'd1, 11'd304,  11'd208,  1'b1, 2'd2, 1'b1};
    vt[14] = '{11'd10, 2'd0, 11'd352,  11'd240,  1'b1, 2'd3, 1'b0};
    vt[15] = '{11'd10, 2'd0, 11'd2000, 11'd2000, 1'b0, 2'd0, 1'b0};
    vt[16] = '{11'd10, 2'd0, 11'd58,   11'd42,   1'b1, 2'd0, 1'b0};

    // Reset state and start positions
    reset_dut();
    rst = 1'b1;
    step();
    chk("reset_outputs", {60'd0, draw, id, ovl}, 64'd0);
    chk("reset_tick", {63'd0, tick}, 64'd0);
    chk_ball("init_ball0", 0, 64, 48, 2, 1);
    chk_ball("init_ball1", 1, 160, 112, -2, -1);
    chk_ball("init_ball3", 3, 352, 240, -2, -1);
    rst = 1'b0;
    drive(64, 48);
    expect_px("post_reset_c1", 1, 1'b0, 2'd0, 1'b0);
    expect_px("post_reset_c2", 2, 1'b0, 2'd0, 1'b0);
    expect_px("post_reset_c3", 3, 1'b1, 2'd0, 1'b0);
    step();
    drive(2000, 2000);
    for (int i = 0; i < 4; i++) step();

    // Render vectors, one per cycle, back to back
    for (int i = 0; i < 17; i++) begin
      radius = vt[i].r;
      mode   = vt[i].m;
      hcnt   = vt[i].h;
      vcnt   = vt[i].v;
      expect_px($sformatf("vec%0d", i), 3, vt[i].d, vt[i].i, vt[i].o);
      step();
    end
    radius = 11'd10;
    mode   = 2'd0;
    drive(2000, 2000);
    for (int i = 0; i < 4; i++) step();

    // Overlap of balls 0 and 1 then a tick
    reset_dut();
    radius = 11'd49;
    mode   = 2'd1;
    drive(112, 80);
    expect_px("overlap01", 3, 1'b1, 2'd0, 1'b1);
    step();
    drive(2000, 2000);
    for (int i = 0; i < 4; i++) step();
    radius = 11'd10;
    mode   = 2'd0;
    frame();
`ifdef BALL_ARRAY_COLLIDE_EN
    chk_ball("collide_ball0", 0, 62, 47, -2, -1);
    chk_ball("collide_ball1", 1, 162, 113, 2, 1);
`else
    chk_ball("nocollide_ball0", 0, 66, 49, 2, 1);
    chk_ball("nocollide_ball1", 1, 158, 111, -2, -1);
`endif

    // Sticky reversal held pending across a frozen tick
    reset_dut();
    opp = 4'b0100;
    step();
    opp = '0;
    step();
    freeze = 1'b1;
    frame();
    freeze = 1'b0;
    chk_ball("frozen_ball2", 2, 256, 176, 2, 1);
    chk_ball("frozen_ball0", 0, 64, 48, 2, 1);
    frame();
    chk_ball("rev_ball2", 2, 254, 175, -2, -1);
    frame();
    chk_ball("rev_once_ball2", 2, 252, 174, -2, -1);
    chk_ball("moving_ball0", 0, 68, 50, 2, 1);

    // Counters held at 0: one tick; reversal request on the tick cycle itself applies
    drive(2000, 2000);
    step();
    drive(0, 0);
    opp   = 4'b0010;
    ntick = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      opp   = '0;
      ntick += int'(tick);
    end
    drive(2000, 2000);
    for (int i = 0; i < 3; i++) begin
      step();
      ntick += int'(tick);
    end
    chk("hold0_ticks", 64'(ntick), 64'd1);
    chk_ball("hold0_ball0", 0, 70, 51, 2, 1);
    chk_ball("tickreq_ball1", 1, 158, 111, 2, 1);

    // Run ball 0 up to the right edge and bounce
    for (int f = 0; f < 400; f++) begin
      if (dut.g_ball[0].u_mot.r_px == 11'd628) break;
      frame();
    end
    chk_ball("edge_628", 0, 628, 330, 2, 1);
    frame();
    chk_ball("edge_629", 0, 629, 331, -2, 1);
    frame();
    chk_ball("edge_627", 0, 627, 332, -2, 1);

    for (int i = 0; i < 10 && sb.size() > 0; i++) step();
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
